// File: rtl/vp_lvp_pipe.sv
// Last-value predictor: tagged table with saturating confidence, two-stage D/E1 output pipeline,
// multi-lane training and a sequential flush sweep. Define VP_LVP_FWD_BYPASS_EN for write-to-lookup forwarding.
module vp_lvp_pipe #(
  parameter int P_NUM_PRED   = 2,
  parameter int P_ENTRIES    = 256,
  parameter int P_TAG_WIDTH  = 10,
  parameter int P_CONF_WIDTH = 3,
  parameter int P_CONF_THRES = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [P_NUM_PRED-1:0][31:1]   fw_pc_i,
  input  logic [P_NUM_PRED-1:0]         fw_valid_i,
  input  logic                          stall_i,
  output logic [P_NUM_PRED-1:0][31:1]   pred_pc_d_o,
  output logic [P_NUM_PRED-1:0][31:0]   pred_result_d_o,
  output logic [P_NUM_PRED-1:0]         pred_conf_d_o,
  output logic [P_NUM_PRED-1:0]         pred_valid_d_o,
  output logic [P_NUM_PRED-1:0][31:1]   pred_pc_e1_o,
  output logic [P_NUM_PRED-1:0][31:0]   pred_result_e1_o,
  output logic [P_NUM_PRED-1:0]         pred_conf_e1_o,
  output logic [P_NUM_PRED-1:0]         pred_valid_e1_o,
  input  logic [P_NUM_PRED-1:0][31:1]   fb_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]   fb_actual_i,
  input  logic [P_NUM_PRED-1:0]         fb_valid_i,
  input  logic                          flush_i,
  output logic                          flush_busy_o
);

  localparam int IDX_W  = $clog2(P_ENTRIES);
  localparam int TAG_LO = IDX_W + 1;
  localparam int TAG_HI = IDX_W + P_TAG_WIDTH;

  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [P_TAG_WIDTH-1:0]  tag_t;
  typedef logic [P_CONF_WIDTH-1:0] conf_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] value;
    conf_t       conf;
  } entry_t;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  localparam conf_t CONF_THR = conf_t'(P_CONF_THRES);
  localparam conf_t CONF_MAX = '1;

  entry_t table_q [P_ENTRIES];
  state_t state_q, state_d;
  idx_t   sweep_q, sweep_d;
  logic   flushing;

  assign flushing     = (state_q == S_FLUSH);
  assign flush_busy_o = flushing;

  // Only idx/tag bits of the feedback PC matter; the rest are deliberately ignored.
  logic fb_pc_unused;
  assign fb_pc_unused = ^fb_pc_i;

  // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      S_IDLE: if (flush_i) begin
        state_d = S_FLUSH;
        sweep_d = '0;
      end
      S_FLUSH: begin
        if (flush_i) begin
          sweep_d = '0;
        end else if (sweep_q == idx_t'(P_ENTRIES - 1)) begin
          state_d = S_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = idx_t'(sweep_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  idx_t   fb_idx [P_NUM_PRED];
  tag_t   fb_tag [P_NUM_PRED];
  entry_t fb_old [P_NUM_PRED];
  entry_t fb_new [P_NUM_PRED];
  logic   fb_hit [P_NUM_PRED];
  logic   fb_win [P_NUM_PRED];

  // Per-lane post-update entry; a lane only wins if no higher lane targets the same index.
  always_comb begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      fb_idx[l]       = fb_pc_i[l][IDX_W:1];
      fb_tag[l]       = fb_pc_i[l][TAG_HI:TAG_LO];
      fb_old[l]       = table_q[fb_idx[l]];
      fb_hit[l]       = fb_old[l].valid && (fb_old[l].tag == fb_tag[l]);
      fb_new[l].valid = 1'b1;
      fb_new[l].tag   = fb_tag[l];
      fb_new[l].value = fb_actual_i[l];
      fb_new[l].conf  = '0;
      if (fb_hit[l] && (fb_old[l].value == fb_actual_i[l]))
        fb_new[l].conf = (fb_old[l].conf == CONF_MAX) ? CONF_MAX : conf_t'(fb_old[l].conf + 1'b1);
      fb_win[l] = fb_valid_i[l] && !flushing;
      for (int h = l + 1; h < P_NUM_PRED; h++)
        if (fb_valid_i[h] && (fb_pc_i[h][IDX_W:1] == fb_idx[l])) fb_win[l] = 1'b0;
    end
  end

  // NOTE: the table is flops, not SRAM, so it is reset; an SRAM macro could not be cleared this way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      table_q <= '{default: '0};
    end else begin
      if (flushing) begin
        table_q[sweep_q].valid <= 1'b0;
        table_q[sweep_q].conf  <= '0;
      end
      for (int l = 0; l < P_NUM_PRED; l++)
        if (fb_win[l]) table_q[fb_idx[l]] <= fb_new[l];
    end
  end

  idx_t   lk_idx [P_NUM_PRED];
  entry_t lk_ent [P_NUM_PRED];
  logic   lk_hit [P_NUM_PRED];

  always_comb begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      lk_idx[l] = fw_pc_i[l][IDX_W:1];
      lk_ent[l] = table_q[lk_idx[l]];
`ifdef VP_LVP_FWD_BYPASS_EN
      for (int f = 0; f < P_NUM_PRED; f++)
        if (fb_win[f] && (fb_idx[f] == lk_idx[l])) lk_ent[l] = fb_new[f];
`endif
      lk_hit[l] = fw_valid_i[l] && !flushing && lk_ent[l].valid
                  && (lk_ent[l].tag == fw_pc_i[l][TAG_HI:TAG_LO]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_pc_d_o      <= '0;
      pred_result_d_o  <= '0;
      pred_conf_d_o    <= '0;
      pred_valid_d_o   <= '0;
      pred_pc_e1_o     <= '0;
      pred_result_e1_o <= '0;
      pred_conf_e1_o   <= '0;
      pred_valid_e1_o  <= '0;
    end else if (!stall_i) begin
      for (int l = 0; l < P_NUM_PRED; l++) begin
        pred_pc_d_o[l]     <= fw_pc_i[l];
        pred_result_d_o[l] <= lk_hit[l] ? lk_ent[l].value : 32'h0;
        pred_conf_d_o[l]   <= lk_hit[l] && (lk_ent[l].conf >= CONF_THR);
      end
      pred_valid_d_o   <= fw_valid_i;
      pred_pc_e1_o     <= pred_pc_d_o;
      pred_result_e1_o <= pred_result_d_o;
      pred_conf_e1_o   <= pred_conf_d_o;
      pred_valid_e1_o  <= pred_valid_d_o;
    end
  end

endmodule

// File: tb/tb_vp_lvp_pipe.sv
// Self-checking bench for vp_lvp_pipe: directed steps plus random traffic against a table-level model.
module tb_vp_lvp_pipe;
  localparam int NP = 2, ENT = 64, IW = 6, TW = 10, CW = 3, TH = 7, CMAX = 7;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NP-1:0][31:1]   fw_pc_i;
  logic [NP-1:0]         fw_valid_i;
  logic                  stall_i;
  logic [NP-1:0][31:1]   pred_pc_d_o, pred_pc_e1_o;
  logic [NP-1:0][31:0]   pred_result_d_o, pred_result_e1_o;
  logic [NP-1:0]         pred_conf_d_o, pred_valid_d_o, pred_conf_e1_o, pred_valid_e1_o;
  logic [NP-1:0][31:1]   fb_pc_i;
  logic [NP-1:0][31:0]   fb_actual_i;
  logic [NP-1:0]         fb_valid_i;
  logic                  flush_i;
  logic                  flush_busy_o;

  vp_lvp_pipe #(.P_NUM_PRED(NP), .P_ENTRIES(ENT), .P_TAG_WIDTH(TW),
                .P_CONF_WIDTH(CW), .P_CONF_THRES(TH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fw_pc_i(fw_pc_i), .fw_valid_i(fw_valid_i),
    .stall_i(stall_i), .pred_pc_d_o(pred_pc_d_o), .pred_result_d_o(pred_result_d_o),
    .pred_conf_d_o(pred_conf_d_o), .pred_valid_d_o(pred_valid_d_o),
    .pred_pc_e1_o(pred_pc_e1_o), .pred_result_e1_o(pred_result_e1_o),
    .pred_conf_e1_o(pred_conf_e1_o), .pred_valid_e1_o(pred_valid_e1_o),
    .fb_pc_i(fb_pc_i), .fb_actual_i(fb_actual_i), .fb_valid_i(fb_valid_i),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o));

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  // Reference model: the table as plain arrays plus the expected D/E1 contents.
  typedef struct { logic [31:1] pc; logic [31:0] res; logic conf; logic vld; } pred_t;
  bit          m_vld  [ENT];
  int          m_tag  [ENT];
  logic [31:0] m_val  [ENT];
  int          m_conf [ENT];
  bit          m_busy;
  int          m_pos;
  pred_t       ed [NP];
  pred_t       ee [NP];

  function automatic int idx_of(input logic [31:1] pc); return int'(pc[IW:1]); endfunction
  function automatic int tag_of(input logic [31:1] pc); return int'(pc[IW+TW:IW+1]); endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_vld[i] = 0; m_tag[i] = 0; m_val[i] = '0; m_conf[i] = 0;
    end
    m_busy = 0; m_pos = 0;
    for (int l = 0; l < NP; l++) begin
      ed[l] = '{pc: '0, res: '0, conf: 1'b0, vld: 1'b0};
      ee[l] = ed[l];
    end
  endtask

  task automatic compare_all();
    for (int l = 0; l < NP; l++) begin
      check($sformatf("d_pc%0d", l),    {1'b0, pred_pc_d_o[l]},  {1'b0, ed[l].pc});
      check($sformatf("d_res%0d", l),   pred_result_d_o[l],      ed[l].res);
      check($sformatf("d_conf%0d", l),  32'(pred_conf_d_o[l]),   32'(ed[l].conf));
      check($sformatf("d_vld%0d", l),   32'(pred_valid_d_o[l]),  32'(ed[l].vld));
      check($sformatf("e1_pc%0d", l),   {1'b0, pred_pc_e1_o[l]}, {1'b0, ee[l].pc});
      check($sformatf("e1_res%0d", l),  pred_result_e1_o[l],     ee[l].res);
      check($sformatf("e1_conf%0d", l), 32'(pred_conf_e1_o[l]),  32'(ee[l].conf));
      check($sformatf("e1_vld%0d", l),  32'(pred_valid_e1_o[l]), 32'(ee[l].vld));
    end
    check("busy", 32'(flush_busy_o), 32'(m_busy));
  endtask

  // One clock: predict from current inputs, advance the model, clock the DUT and compare.
  task automatic step();
    bit          n_vld  [ENT];
    int          n_tag  [ENT];
    logic [31:0] n_val  [ENT];
    int          n_conf [ENT];
    n_vld = m_vld; n_tag = m_tag; n_val = m_val; n_conf = m_conf;
    if (!m_busy) begin
      for (int l = 0; l < NP; l++) begin
        bit dropped = 0;
        int i, t;
        for (int h = l + 1; h < NP; h++)
          if (fb_valid_i[h] && idx_of(fb_pc_i[h]) == idx_of(fb_pc_i[l])) dropped = 1;
        if (!fb_valid_i[l] || dropped) continue;
        i = idx_of(fb_pc_i[l]); t = tag_of(fb_pc_i[l]);
        if (m_vld[i] && m_tag[i] == t) begin
          if (m_val[i] == fb_actual_i[l]) n_conf[i] = (m_conf[i] < CMAX) ? m_conf[i] + 1 : CMAX;
          else begin n_val[i] = fb_actual_i[l]; n_conf[i] = 0; end
        end else begin
          n_vld[i] = 1; n_tag[i] = t; n_val[i] = fb_actual_i[l]; n_conf[i] = 0;
        end
      end
    end
    if (!stall_i) begin
      ee = ed;
      for (int l = 0; l < NP; l++) begin
        int i = idx_of(fw_pc_i[l]);
        bit hit;
        int cf;
        logic [31:0] v;
`ifdef VP_LVP_FWD_BYPASS_EN
        hit = n_vld[i] && n_tag[i] == tag_of(fw_pc_i[l]); v = n_val[i]; cf = n_conf[i];
`else
        hit = m_vld[i] && m_tag[i] == tag_of(fw_pc_i[l]); v = m_val[i]; cf = m_conf[i];
`endif
        hit = hit && fw_valid_i[l] && !m_busy;
        ed[l].pc   = fw_pc_i[l];
        ed[l].res  = hit ? v : 32'h0;
        ed[l].conf = hit && (cf >= TH);
        ed[l].vld  = fw_valid_i[l];
      end
    end
    if (m_busy) begin
      n_vld[m_pos] = 0; n_conf[m_pos] = 0;
      if (flush_i) m_pos = 0;
      else if (m_pos == ENT - 1) begin m_busy = 0; m_pos = 0; end
      else m_pos++;
    end else if (flush_i) begin
      m_busy = 1; m_pos = 0;
    end
    m_vld = n_vld; m_tag = n_tag; m_val = n_val; m_conf = n_conf;
    @(posedge clk_i); #1;
    compare_all();
  endtask

  function automatic logic [31:1] mk_pc(input int tag, input int idx);
    logic [30:0] v;
    v = {15'($urandom), 10'(tag), 6'(idx)};
    return v;
  endfunction

  task automatic idle();
    fw_valid_i = '0; fb_valid_i = '0; stall_i = 0; flush_i = 0;
  endtask

  task automatic rand_inputs(input int stall_pct);
    for (int l = 0; l < NP; l++) begin
      fw_pc_i[l]     = mk_pc($urandom_range(0, 2), $urandom_range(0, 3));
      fb_pc_i[l]     = mk_pc($urandom_range(0, 2), $urandom_range(0, 3));
      fb_actual_i[l] = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1));
    end
    fw_valid_i = 2'($urandom);
    fb_valid_i = 2'($urandom);
    stall_i    = ($urandom_range(0, 99) < stall_pct);
    flush_i    = 0;
  endtask

  task automatic lookup0(input logic [31:1] pc);
    idle(); fw_pc_i[0] = pc; fw_valid_i[0] = 1;
  endtask

  task automatic feedback0(input logic [31:1] pc, input logic [31:0] val);
    idle(); fb_pc_i[0] = pc; fb_actual_i[0] = val; fb_valid_i[0] = 1;
  endtask

  initial begin
    pred_t snap_d, snap_e;
    int cnt;
    rst_ni = 0;
    model_reset();
    // Reset held with random inputs: all outputs stay zero.
    for (int c = 0; c < 4; c++) begin
      rand_inputs(30); flush_i = 1'($urandom);
      @(posedge clk_i); #1;
      check("rst_res_d", pred_result_d_o[0], 32'h0);
      check("rst_vld_d", 32'(pred_valid_d_o), 32'h0);
      check("rst_vld_e1", 32'(pred_valid_e1_o), 32'h0);
      check("rst_busy", 32'(flush_busy_o), 32'h0);
    end
    @(negedge clk_i); rst_ni = 1;
    lookup0(31'h80); fw_valid_i[1] = 1; fw_pc_i[1] = mk_pc(1, 3); step();
    check("post_rst_miss", pred_result_d_o[0], 32'h0);

    // Training: 7 feedbacks leave confidence below threshold, the 8th crosses it.
    for (int k = 0; k < 7; k++) begin feedback0(31'h80, 32'hDEADBEEF); step(); end
    lookup0(31'h80); step();
    check("train7_res", pred_result_d_o[0], 32'hDEADBEEF);
    check("train7_conf", 32'(pred_conf_d_o[0]), 32'h0);
    feedback0(31'h80, 32'hDEADBEEF); step();
    lookup0(31'h80); step();
    check("train8_conf_d", 32'(pred_conf_d_o[0]), 32'h1);
    idle(); step();
    check("train8_res_e1", pred_result_e1_o[0], 32'hDEADBEEF);
    check("train8_conf_e1", 32'(pred_conf_e1_o[0]), 32'h1);

    // Mismatch retrains, aliased tag misses.
    feedback0(31'h80, 32'h12345678); step();
    lookup0(31'h80); step();
    check("mism_res", pred_result_d_o[0], 32'h12345678);
    check("mism_conf", 32'(pred_conf_d_o[0]), 32'h0);
    lookup0(31'hC0); step();
    check("alias_miss", pred_result_d_o[0], 32'h0);

    // Same-index feedback on both lanes: lane 1 wins.
    idle();
    fb_pc_i[0] = 31'h10; fb_actual_i[0] = 32'h1111; fb_valid_i[0] = 1;
    fb_pc_i[1] = 31'h10; fb_actual_i[1] = 32'h2222; fb_valid_i[1] = 1;
    step();
    lookup0(31'h10); step();
    check("lane_conflict", pred_result_d_o[0], 32'h2222);

    // Same-cycle lookup and feedback on one index.
    lookup0(31'h10); fb_pc_i[1] = 31'h10; fb_actual_i[1] = 32'h3333; fb_valid_i[1] = 1; step();
    lookup0(31'h10); step();
    check("after_rbw", pred_result_d_o[0], 32'h3333);

    // Stall: D/E1 frozen while inputs change, table keeps training.
    lookup0(31'h80); step();
    lookup0(31'h10); step();
    snap_d = ed[0]; snap_e = ee[0];
    for (int k = 0; k < 3; k++) begin
      rand_inputs(0); stall_i = 1; step();
      check("stall_d_res", pred_result_d_o[0], snap_d.res);
      check("stall_e1_res", pred_result_e1_o[0], snap_e.res);
    end
    lookup0(31'hC0); step();
    check("unstall_pc", {1'b0, pred_pc_d_o[0]}, 32'h000000C0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin rand_inputs(12); step(); end

    // Flush from a trained table: busy for ENT cycles, feedback ignored, lookups miss afterward.
    feedback0(31'h80, 32'hCAFE0001); step();
    idle(); flush_i = 1; step();
    cnt = flush_busy_o ? 1 : 0;
    for (int g = 0; g < 200 && flush_busy_o; g++) begin
      rand_inputs(10); step();
      if (flush_busy_o) cnt++;
    end
    check("flush_len", cnt, ENT);
    lookup0(31'h80); step();
    check("flush_miss80", pred_result_d_o[0], 32'h0);
    lookup0(31'h10); step();
    check("flush_miss10", pred_result_d_o[0], 32'h0);

    // Restart mid-flush.
    for (int k = 0; k < 20; k++) begin rand_inputs(0); step(); end
    idle(); flush_i = 1; step();
    for (int k = 0; k < 9; k++) begin rand_inputs(10); step(); end
    idle(); flush_i = 1; step();
    cnt = flush_busy_o ? 1 : 0;
    for (int g = 0; g < 200 && flush_busy_o; g++) begin
      rand_inputs(10); step();
      if (flush_busy_o) cnt++;
    end
    check("flush_restart_len", cnt, ENT);

    // Reset asserted mid-flush.
    for (int k = 0; k < 30; k++) begin rand_inputs(10); step(); end
    idle(); flush_i = 1; step();
    for (int k = 0; k < 5; k++) begin rand_inputs(0); step(); end
    @(negedge clk_i); rst_ni = 0; #1;
    model_reset();
    check("midflush_rst_busy", 32'(flush_busy_o), 32'h0);
    check("midflush_rst_vld", 32'(pred_valid_d_o), 32'h0);
    @(negedge clk_i); rst_ni = 1;
    for (int k = 0; k < 200; k++) begin rand_inputs(12); step(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vp_lvp_pipe.md
Name: vp_lvp_pipe

Overview:
- Parametrised last-value predictor with P_NUM_PRED lanes, a tagged register table and saturating confidence counters.
- Two-stage registered prediction pipeline (ALN lookup -> D output -> E1 output) with stall.
- Multi-lane feedback training and a sequential table-flush state machine.
- Instantiated behind the value-predictor wrapper as the generalised successor to the baseline predictor.

Parameters:
- P_NUM_PRED, 2, number of prediction and feedback lanes (1..4).
- P_ENTRIES, 256, table entries; power of two; IDX_W = $clog2(P_ENTRIES).
- P_TAG_WIDTH, 10, tag bits per entry; IDX_W + P_TAG_WIDTH <= 30.
- P_CONF_WIDTH, 3, confidence counter width.
- P_CONF_THRES, 7, counter value at or above which a prediction is confident (<= 2^P_CONF_WIDTH-1).

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fw_pc_i  in  [P_NUM_PRED][31:1]  lookup PC per lane, ALN stage.
- fw_valid_i  in  [P_NUM_PRED]  lookup qualifier.
- stall_i  in  1  freezes D and E1 pipeline registers.
- pred_pc_d_o  out  [P_NUM_PRED][31:1]  PC at D.
- pred_result_d_o  out  [P_NUM_PRED][31:0]  predicted value at D.
- pred_conf_d_o  out  [P_NUM_PRED]  confident flag at D.
- pred_valid_d_o  out  [P_NUM_PRED]  delayed fw_valid_i.
- pred_pc_e1_o, pred_result_e1_o, pred_conf_e1_o, pred_valid_e1_o  out  as D  same fields one stage later.
- fb_pc_i  in  [P_NUM_PRED][31:1]  feedback PC.
- fb_actual_i  in  [P_NUM_PRED][31:0]  executed result.
- fb_valid_i  in  [P_NUM_PRED]  feedback qualifier.
- flush_i  in  1  single-cycle pulse; starts table flush.
- flush_busy_o  out  1  high while flush is in progress.

Behaviour:
- Reset (async assert, sync release):
  - every entry has valid=0, tag=0, value=0, conf=0.
  - all D/E1 outputs and flush_busy_o are 0; FSM is IDLE.
- Indexing: idx = pc[IDX_W:1]; tag = pc[IDX_W+P_TAG_WIDTH:IDX_W+1].
- Lookup, per lane, in the cycle fw_valid_i is sampled:
  - hit = entry.valid AND tag match.
  - D registers capture pc, value (0 on miss), conf = hit AND (conf >= P_CONF_THRES), and valid. Latency is 1 cycle.
  - E1 registers capture the D registers. Latency is 2 cycles.
- Stall: while stall_i=1, D and E1 hold their contents and fw inputs are ignored. The table still trains.
- Feedback, per valid lane, written at the clock edge:
  - miss: allocate with valid=1, tag, value=fb_actual_i, conf=0.
  - hit and value equal: conf saturating +1; holds at 2^P_CONF_WIDTH-1.
  - hit and value differs: value=fb_actual_i, conf=0.
- Simultaneous feedback to the same idx: the highest-numbered lane wins; lower lanes to that idx are dropped.
- Same-cycle lookup and feedback on the same idx: lookup returns the pre-update contents (read-before-write). The optional bypass below changes this.
- Flush FSM:
  - IDLE -> FLUSH on flush_i.
  - In FLUSH, a sweep counter runs 0..P_ENTRIES-1, clearing valid and conf of one entry per cycle.
  - FLUSH -> IDLE after entry P_ENTRIES-1 is cleared. flush_busy_o is high for exactly P_ENTRIES cycles, starting the cycle after flush_i.
  - flush_i received during FLUSH restarts the counter at 0.
  - During FLUSH, all feedback writes are dropped and all lookups report miss (conf=0, result=0); valid still propagates.
- Reset asserted mid-flush: immediate return to IDLE with the table cleared.

Optional Feature:
- Macro VP_LVP_FWD_BYPASS_EN.
- Defined: a lookup that matches a same-cycle feedback write (same idx, feedback not dropped) returns the post-update value, hit and conf, with winning-lane priority applied.
- Undefined: strict read-before-write as specified above.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> all outputs 0 and flush_busy_o=0. Release -> a lookup of any PC returns result 0, conf 0.
- Training (P_ENTRIES=64, P_CONF_WIDTH=3, P_CONF_THRES=7): 8 feedbacks on lane 0, pc=0x80, actual 0xDEADBEEF -> lookup of 0x80 gives pred_result_d_o=0xDEADBEEF, conf=1 one cycle later and the same on E1 a cycle after. After only 7 feedbacks -> conf=0.
- Mismatch: after the training case, one feedback of 0x12345678 -> next lookup gives 0x12345678, conf=0. Aliased pc 0x80+0x40 (same idx, different tag) -> miss.
- Lane conflict: same cycle, lane0 feedback pc=0x10 value 0x1111 and lane1 pc=0x10 value 0x2222 -> stored value 0x2222.
- Stall: stall_i=1 for 3 cycles while fw inputs change -> D and E1 outputs constant. Release -> resumes with the next sampled inputs.
- Flush: pulse flush_i with a trained table -> flush_busy_o high 64 cycles; feedback during flush has no effect; afterwards all lookups miss. A second pulse at cycle 10 -> busy lasts 64 cycles from the restart.
